// File: rtl/chma_cline_req_sequencer.sv
// Chroma cache-line request sequencer: splits a reference block into the
// covering cache lines and issues them one per handshake in raster order.
module chma_cline_req_sequencer #(
    parameter int C_L_H_SIZE_C  = 3,
    parameter int C_L_V_SIZE_C  = 2,
    parameter int CHMA_DIM_WDTH = 4,
    parameter int CHMA_DIM_HIGT = 4,
    parameter int X_WDTH        = 11,
    parameter int Y_WDTH        = 11
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid_in,
    output logic                             req_ready_out,
    input  logic [X_WDTH-1:0]                start_x_in,
    input  logic [Y_WDTH-1:0]                start_y_in,
    input  logic [CHMA_DIM_WDTH-1:0]         rf_blk_wdt_in,
    input  logic [CHMA_DIM_HIGT-1:0]         rf_blk_hgt_in,
    input  logic                             flush_in,
    output logic                             cl_valid_out,
    input  logic                             cl_ready_in,
    output logic [X_WDTH-C_L_H_SIZE_C-1:0]   cl_x_out,
    output logic [Y_WDTH-C_L_V_SIZE_C-1:0]   cl_y_out,
    output logic [3:0]                       cl_idx_out,
    output logic                             cl_last_out,
    output logic [4:0]                       num_clines_out,
    output logic                             busy_out
);

    localparam int CLX_W = X_WDTH - C_L_H_SIZE_C;
    localparam int CLY_W = Y_WDTH - C_L_V_SIZE_C;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]       state;
    logic [CLX_W-1:0] base_x;
    logic [CLY_W-1:0] base_y;
    logic [1:0]       dx;
    logic [1:0]       dy;
    logic [1:0]       ix;
    logic [1:0]       iy;
    logic [3:0]       cl_idx;
    logic [4:0]       num_clines;

    logic [X_WDTH:0]  end_x;
    logic [Y_WDTH:0]  end_y;
    logic [X_WDTH:0]  end_col_x;
    logic [Y_WDTH:0]  end_row_y;
    logic [X_WDTH:0]  base_col_x;
    logic [Y_WDTH:0]  base_row_y;
    logic [1:0]       dx_new;
    logic [1:0]       dy_new;
    logic [4:0]       num_clines_new;
    logic             at_last;
    logic             accept;

    // End coordinates carry one extra bit so a block crossing the picture
    // edge still yields the correct 2-bit line span.
    assign end_x      = {1'b0, start_x_in} + {{(X_WDTH+1-CHMA_DIM_WDTH){1'b0}}, rf_blk_wdt_in};
    assign end_y      = {1'b0, start_y_in} + {{(Y_WDTH+1-CHMA_DIM_HIGT){1'b0}}, rf_blk_hgt_in};
    assign end_col_x  = end_x >> C_L_H_SIZE_C;
    assign end_row_y  = end_y >> C_L_V_SIZE_C;
    assign base_col_x = {1'b0, start_x_in} >> C_L_H_SIZE_C;
    assign base_row_y = {1'b0, start_y_in} >> C_L_V_SIZE_C;
    assign dx_new     = 2'(end_col_x - base_col_x);
    assign dy_new     = 2'(end_row_y - base_row_y);

    assign num_clines_new = ({3'b000, dx_new} + 5'd1) * ({3'b000, dy_new} + 5'd1);

    assign accept  = (state == IDLE) && req_valid_in;
    assign at_last = (ix == dx) && (iy == dy);

    assign req_ready_out  = (state == IDLE);
    assign busy_out       = (state != IDLE);
    assign cl_valid_out   = (state == ISSUE);
    assign cl_last_out    = (state == ISSUE) && at_last;
    assign cl_x_out       = base_x + {{(CLX_W-2){1'b0}}, ix};
    assign cl_y_out       = base_y + {{(CLY_W-2){1'b0}}, iy};
    assign cl_idx_out     = cl_idx;
    assign num_clines_out = num_clines;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            base_x     <= '0;
            base_y     <= '0;
            dx         <= '0;
            dy         <= '0;
            ix         <= '0;
            iy         <= '0;
            cl_idx     <= '0;
            num_clines <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        base_x     <= CLX_W'(base_col_x);
                        base_y     <= CLY_W'(base_row_y);
                        dx         <= dx_new;
                        dy         <= dy_new;
                        ix         <= '0;
                        iy         <= '0;
                        cl_idx     <= '0;
                        num_clines <= num_clines_new;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Flush wins over a same-cycle line handshake.
                    if (flush_in) begin
                        state <= IDLE;
                    end else if (cl_ready_in) begin
                        if (at_last) begin
                            state <= IDLE;
                        end else begin
                            cl_idx <= cl_idx + 4'd1;
                            if (ix == dx) begin
                                ix <= '0;
                                iy <= iy + 2'd1;
                            end else begin
                                ix <= ix + 2'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chma_cline_req_sequencer.sv
// Bench for chma_cline_req_sequencer: a line-list model expands each accepted
// request and every output is compared against it on each falling edge.
module tb_chma_cline_req_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_in;
    logic        req_ready_out;
    logic [10:0] start_x_in;
    logic [10:0] start_y_in;
    logic [3:0]  rf_blk_wdt_in;
    logic [3:0]  rf_blk_hgt_in;
    logic        flush_in;
    logic        cl_valid_out;
    logic        cl_ready_in;
    logic [7:0]  cl_x_out;
    logic [8:0]  cl_y_out;
    logic [3:0]  cl_idx_out;
    logic        cl_last_out;
    logic [4:0]  num_clines_out;
    logic        busy_out;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int x;
        int y;
        int idx;
        bit last;
    } line_t;

    line_t q[$];
    bit    m_busy = 1'b0;
    int    m_num  = 0;

    chma_cline_req_sequencer #(
        .C_L_H_SIZE_C (3),
        .C_L_V_SIZE_C (2),
        .CHMA_DIM_WDTH(4),
        .CHMA_DIM_HIGT(4),
        .X_WDTH       (11),
        .Y_WDTH       (11)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .start_x_in    (start_x_in),
        .start_y_in    (start_y_in),
        .rf_blk_wdt_in (rf_blk_wdt_in),
        .rf_blk_hgt_in (rf_blk_hgt_in),
        .flush_in      (flush_in),
        .cl_valid_out  (cl_valid_out),
        .cl_ready_in   (cl_ready_in),
        .cl_x_out      (cl_x_out),
        .cl_y_out      (cl_y_out),
        .cl_idx_out    (cl_idx_out),
        .cl_last_out   (cl_last_out),
        .num_clines_out(num_clines_out),
        .busy_out      (busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Columns of 8 samples, rows of 4 rows; span beyond 3 wraps to 2 bits.
    task automatic model_accept(input int sx, input int w, input int sy, input int h);
        int fc, lc, fr, lr, nc, nr;
        fc = sx / 8;
        lc = (sx + w) / 8;
        fr = sy / 4;
        lr = (sy + h) / 4;
        nc = ((lc - fc) % 4) + 1;
        nr = ((lr - fr) % 4) + 1;
        q.delete();
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++)
                q.push_back('{x: (fc + c) % 256, y: (fr + r) % 512, idx: r * nc + c,
                              last: (r == nr - 1) && (c == nc - 1)});
        m_num  = nc * nr;
        m_busy = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            m_busy = 1'b0;
            m_num  = 0;
            q.delete();
            chk("rst_ready", 32'(req_ready_out), 1);
            chk("rst_valid", 32'(cl_valid_out), 0);
            chk("rst_busy",  32'(busy_out), 0);
            chk("rst_last",  32'(cl_last_out), 0);
            chk("rst_idx",   32'(cl_idx_out), 0);
            chk("rst_num",   32'(num_clines_out), 0);
        end else begin
            chk("ready", 32'(req_ready_out), 32'(!m_busy));
            chk("busy",  32'(busy_out), 32'(m_busy));
            chk("valid", 32'(cl_valid_out), 32'(m_busy));
            chk("num",   32'(num_clines_out), m_num);
            if (m_busy) begin
                chk("cl_x",  32'(cl_x_out), q[0].x);
                chk("cl_y",  32'(cl_y_out), q[0].y);
                chk("idx",   32'(cl_idx_out), q[0].idx);
                chk("last",  32'(cl_last_out), 32'(q[0].last));
            end else begin
                chk("idle_last", 32'(cl_last_out), 0);
            end
            if (!m_busy) begin
                if (req_valid_in)
                    model_accept(int'(start_x_in), int'(rf_blk_wdt_in),
                                 int'(start_y_in), int'(rf_blk_hgt_in));
            end else if (flush_in) begin
                q.delete();
                m_busy = 1'b0;
            end else if (cl_ready_in) begin
                void'(q.pop_front());
                if (q.size() == 0) m_busy = 1'b0;
            end
        end
    end

    // Inputs are scrambled after the accept cycle to show they are latched.
    task automatic issue(input int sx, input int w, input int sy, input int h, input bit flsh);
        req_valid_in  = 1'b1;
        start_x_in    = 11'(sx);
        rf_blk_wdt_in = 4'(w);
        start_y_in    = 11'(sy);
        rf_blk_hgt_in = 4'(h);
        flush_in      = flsh;
        @(posedge clk); #1;
        req_valid_in  = 1'b0;
        flush_in      = 1'b0;
        start_x_in    = 11'h5a5;
        start_y_in    = 11'h2d2;
        rf_blk_wdt_in = 4'hf;
        rf_blk_hgt_in = 4'hf;
    endtask

    task automatic drain(input bit toggle, output int vcyc, output int lidx,
                         output int lx, output int ly);
        int  n;
        bit  r;
        n = 0; r = 1'b0; vcyc = 0; lidx = -1; lx = -1; ly = -1;
        while (busy_out && n < 200) begin
            cl_ready_in = toggle ? r : 1'b1;
            r = ~r;
            if (cl_valid_out) begin
                vcyc++;
                if (cl_last_out && cl_ready_in) begin
                    lidx = int'(cl_idx_out);
                    lx   = int'(cl_x_out);
                    ly   = int'(cl_y_out);
                end
            end
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 1, 0);
        cl_ready_in = 1'b1;
    endtask

    initial begin
        int vc, li, lx, ly, n;
        reset = 1'b0;
        req_valid_in = 1'b0;
        flush_in = 1'b0;
        cl_ready_in = 1'b1;
        start_x_in = '0;
        start_y_in = '0;
        rf_blk_wdt_in = '0;
        rf_blk_hgt_in = '0;
        #12 reset = 1'b1;
        @(posedge clk); #1;

        issue(5, 2, 3, 4, 1'b0);
        chk("r35_num", 32'(num_clines_out), 2);
        drain(1'b0, vc, li, lx, ly);
        chk("r35_cycles", vc, 2);
        chk("r35_last_y", ly, 1);

        issue(7, 9, 3, 5, 1'b0);
        chk("r36_num", 32'(num_clines_out), 9);
        drain(1'b0, vc, li, lx, ly);
        chk("r36_cycles", vc, 9);
        chk("r36_last_idx", li, 8);
        chk("r36_last_xy", lx * 16 + ly, 2 * 16 + 2);

        issue(7, 9, 3, 5, 1'b0);
        drain(1'b1, vc, li, lx, ly);
        chk("r37_cycles", vc, 18);
        chk("r37_last_idx", li, 8);

        issue(2047, 1, 0, 0, 1'b0);
        chk("r38_x0", 32'(cl_x_out), 255);
        chk("r38_y0", 32'(cl_y_out), 0);
        @(posedge clk); #1;
        chk("r38_x1", 32'(cl_x_out), 0);
        chk("r38_last1", 32'(cl_last_out), 1);
        drain(1'b0, vc, li, lx, ly);

        issue(0, 0, 2047, 1, 1'b0);
        drain(1'b0, vc, li, lx, ly);
        chk("ywrap_last_y", ly, 0);

        issue(8, 0, 3, 15, 1'b0);
        chk("dy_trunc_num", 32'(num_clines_out), 1);
        drain(1'b0, vc, li, lx, ly);

        issue(7, 9, 3, 5, 1'b0);
        n = 0;
        while (cl_idx_out != 4'd2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("r39_reach_idx2", 32'(cl_idx_out), 2);
        flush_in = 1'b1;
        cl_ready_in = 1'b1;
        @(posedge clk); #1;
        flush_in = 1'b0;
        chk("r39_valid", 32'(cl_valid_out), 0);
        chk("r39_ready", 32'(req_ready_out), 1);
        issue(0, 15, 0, 7, 1'b0);
        chk("r39_new_idx", 32'(cl_idx_out), 0);
        chk("r39_new_num", 32'(num_clines_out), 4);
        drain(1'b0, vc, li, lx, ly);
        chk("r39_new_cycles", vc, 4);

        issue(100, 3, 50, 3, 1'b1);
        chk("idle_flush_busy", 32'(busy_out), 1);
        drain(1'b0, vc, li, lx, ly);
        chk("idle_flush_cycles", vc, 2);

        issue(7, 9, 3, 5, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("r40_valid", 32'(cl_valid_out), 0);
        chk("r40_ready", 32'(req_ready_out), 1);
        chk("r40_busy",  32'(busy_out), 0);
        chk("r40_idx",   32'(cl_idx_out), 0);
        chk("r40_num",   32'(num_clines_out), 0);
        @(posedge clk); #1;
        chk("r40_hold_valid", 32'(cl_valid_out), 0);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        issue(5, 2, 3, 4, 1'b0);
        chk("r40_new_idx", 32'(cl_idx_out), 0);
        drain(1'b0, vc, li, lx, ly);
        chk("r40_new_cycles", vc, 2);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
